// File: rtl/layer_sequencer.sv
// Sequences a forward pass through N_LAYERS conv layers: shift, start/wait/capture per layer, latch.
// Define LAYER_SEQ_PROFILE_EN to build the cycles_last/frames profiling counters.
module layer_sequencer #(
  parameter int unsigned N_LAYERS = 3,
  parameter int unsigned TIMEOUT  = 4095,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned CAP_W   = (N_LAYERS > 1) ? N_LAYERS - 1 : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic [N_LAYERS-1:0] conv_done,
  input  logic                clr_err,
  output logic                lsb_shift,
  output logic [N_LAYERS-1:0] conv_start,
  output logic [CAP_W-1:0]    cache_capture,
  output logic                out_latch,
  output logic                busy,
  output logic [2:0]          layer_idx,
  output logic                overrun,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    cycles_last,
  output logic [CNT_W-1:0]    frames
);

  typedef enum logic [2:0] {StIdle, StShift, StStart, StWait, StCapture, StLatch} state_e;

  state_e              state_q;
  logic [N_LAYERS-1:0] layer_oh_q;
  logic [15:0]         wait_cnt_q;
  logic                done_sel;
  logic                last_layer;
  logic                accept;
  logic                done_go;
  logic                latch_go;

  assign done_sel   = |(conv_done & layer_oh_q);
  assign last_layer = layer_oh_q[N_LAYERS-1];
  assign accept     = ((state_q == StIdle) || (state_q == StLatch)) && sample_tick;
  // The first WAIT cycle still sees out_v from the previous frame, so it is skipped.
  assign done_go    = (state_q == StWait) && (wait_cnt_q != 16'd1) && done_sel;
  assign latch_go   = done_go && last_layer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      layer_oh_q    <= '0;
      wait_cnt_q    <= '0;
      lsb_shift     <= 1'b0;
      conv_start    <= '0;
      cache_capture <= '0;
      out_latch     <= 1'b0;
      busy          <= 1'b0;
      layer_idx     <= '0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      lsb_shift     <= 1'b0;
      conv_start    <= '0;
      cache_capture <= '0;
      out_latch     <= 1'b0;
      if (clr_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      unique case (state_q)
        StIdle, StLatch: begin
          layer_idx <= '0;
          if (accept) begin
            state_q   <= StShift;
            lsb_shift <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StShift: begin
          state_q    <= StStart;
          layer_oh_q <= N_LAYERS'(1);
          conv_start <= N_LAYERS'(1);
          layer_idx  <= '0;
        end
        StStart: begin
          state_q    <= StWait;
          wait_cnt_q <= 16'd1;
        end
        StWait: begin
          if (done_go) begin
            if (last_layer) begin
              state_q   <= StLatch;
              out_latch <= 1'b1;
              layer_idx <= '0;
            end else begin
              state_q       <= StCapture;
              cache_capture <= layer_oh_q[CAP_W-1:0];
            end
          end else if (wait_cnt_q == 16'(TIMEOUT)) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            layer_idx   <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StCapture: begin
          state_q    <= StStart;
          layer_oh_q <= layer_oh_q << 1;
          conv_start <= layer_oh_q << 1;
          layer_idx  <= layer_idx + 3'd1;
        end
        default: state_q <= StIdle;
      endcase
      // A tick mid-pass is dropped; the set overrides a simultaneous clear.
      if (sample_tick && !((state_q == StIdle) || (state_q == StLatch))) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef LAYER_SEQ_PROFILE_EN
  logic [CNT_W-1:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= '0;
      cycles_last <= '0;
      frames      <= '0;
    end else begin
      if (accept) begin
        cyc_q <= CNT_W'(1);
      end else if (state_q != StIdle) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if (latch_go) begin
        cycles_last <= cyc_q + CNT_W'(1);
        frames      <= frames + CNT_W'(1);
      end
    end
  end
`else
  assign cycles_last = '0;
  assign frames      = '0;
`endif

endmodule
